rgmii_rx_framer: RTL

//  Receive-side framer behind the RGMII DDR input capture, in the rx_clk domain.

---
 rtl/rgmii_pkg.sv | 24 ++
 rtl/rgmii_inband_status.sv | 53 +++++
 rtl/rgmii_rx_framer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared constants, framer state type and speed helper for the RGMII receive path.
package rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [3:0] PRE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB  = 4'hD;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } framer_state_t;

  // 10M and 100M carry one nibble per rx_clk; 2'b11 behaves as 1000M.
  function automatic logic is_nibble(input logic [1:0] spd);
    return (spd == SPD_10) || (spd == SPD_100);
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band link status filter: decodes {duplex, speed, link} from inter-frame nibbles.
// Latency STATUS_STABLE cycles of a steady value; no backpressure.
module rgmii_inband_status
  import rgmii_pkg::*;
#(
  parameter int STATUS_STABLE = 4
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       in_dv,
  input  logic       in_er,
  input  logic [3:0] in_nib,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex
);

  localparam int RUN_W = $clog2(STATUS_STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STATUS_STABLE);

  logic [3:0]       cand;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] next_run;

  always_comb begin
    next_run = RUN_W'(1);
    if ((in_nib == cand) && (run != '0)) begin
      next_run = (run == RUN_MAX) ? run : run + 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      cand        <= '0;
      run         <= '0;
      link_up     <= 1'b0;
      link_speed  <= SPD_10;
      link_duplex <= 1'b0;
    end else if (!in_dv && !in_er) begin
      cand <= in_nib;
      run  <= next_run;
      if (next_run == RUN_MAX) begin
        link_duplex <= in_nib[3];
        link_speed  <= in_nib[2:1];
        link_up     <= in_nib[0];
      end
    end else begin
      // Any frame or error activity breaks the run of identical samples.
      run <= '0;
    end
  end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII rx framer: nibble packing, preamble/SFD strip, SOF/EOF/ERR tagging, frame counters.
// 1000M latency 2 cycles, no backpressure; `RGMII_INBAND_STATUS_EN adds in-band link status.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
`ifdef RGMII_INBAND_STATUS_EN
  ,
  parameter int STATUS_STABLE = 4
`endif
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic [1:0]       speed_mode,
  input  logic [7:0]       in_data,
  input  logic             in_dv,
  input  logic             in_er,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

  logic [1:0] src_speed;

`ifdef RGMII_INBAND_STATUS_EN
  rgmii_inband_status #(
    .STATUS_STABLE(STATUS_STABLE)
  ) u_status (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .in_dv       (in_dv),
    .in_er       (in_er),
    .in_nib      (in_data[3:0]),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );
  assign src_speed = link_speed;
`else
  assign link_up     = 1'b1;
  assign link_duplex = 1'b1;
  assign link_speed  = speed_mode;
  assign src_speed   = speed_mode;
`endif

  framer_state_t    state;
  logic [1:0]       eff_speed;
  logic [7:0]       hold;
  logic             hold_full;
  logic             first_pend;
  logic [3:0]       nib_lo;
  logic             nib_phase;
  logic             pre_nib5;
  logic             err_seen;
  logic             trunc_pend;
  logic [LEN_W-1:0] byte_cnt;

  logic       byte_done;
  logic [7:0] byte_val;
  logic       eof_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    byte_done = 1'b0;
    byte_val  = in_data;
    if (in_dv && (state == DATA)) begin
      if (!is_nibble(eff_speed)) begin
        byte_done = 1'b1;
      end else if (nib_phase) begin
        byte_done = 1'b1;
        byte_val  = {in_data[3:0], nib_lo};
      end
    end
  end

  // A half-assembled byte at end of carrier is dribble and marks the frame bad.
  assign eof_err = err_seen | (is_nibble(eff_speed) & nib_phase);

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state      <= IDLE;
      eff_speed  <= SPD_10;
      hold       <= '0;
      hold_full  <= 1'b0;
      first_pend <= 1'b0;
      nib_lo     <= '0;
      nib_phase  <= 1'b0;
      pre_nib5   <= 1'b0;
      err_seen   <= 1'b0;
      trunc_pend <= 1'b0;
      byte_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (in_dv) begin
            state     <= PREAMBLE;
            eff_speed <= src_speed;
            pre_nib5  <= (in_data[3:0] == PRE_NIB);
          end
        end

        PREAMBLE: begin
          if (!in_dv) begin
            state <= IDLE;
          end else begin
            pre_nib5 <= (in_data[3:0] == PRE_NIB);
            if (is_nibble(eff_speed) ? (pre_nib5 && (in_data[3:0] == SFD_NIB))
                                     : (in_data == SFD_BYTE)) begin
              state      <= DATA;
              hold_full  <= 1'b0;
              first_pend <= 1'b1;
              nib_phase  <= 1'b0;
              err_seen   <= 1'b0;
              trunc_pend <= 1'b0;
              byte_cnt   <= '0;
            end
          end
        end

        DATA: begin
          if (!in_dv) begin
            if (hold_full) begin
              out_valid <= 1'b1;
              out_data  <= hold;
              out_sof   <= first_pend;
              out_eof   <= 1'b1;
              out_err   <= eof_err;
              if (eof_err) err_cnt <= sat_inc(err_cnt);
              else         frame_cnt <= sat_inc(frame_cnt);
            end
            hold_full <= 1'b0;
            nib_phase <= 1'b0;
            state     <= IDLE;
          end else begin
            if (in_er) err_seen <= 1'b1;
            if (is_nibble(eff_speed)) begin
              nib_phase <= ~nib_phase;
              if (!nib_phase) nib_lo <= in_data[3:0];
            end
            if (byte_done) begin
              if (hold_full) begin
                out_valid  <= 1'b1;
                out_data   <= hold;
                out_sof    <= first_pend;
                first_pend <= 1'b0;
              end
              hold      <= byte_val;
              hold_full <= 1'b1;
              // The MAX_LEN-th byte sits in hold and leaves next cycle as a bad EOF.
              if (byte_cnt == LAST_IDX) begin
                trunc_pend <= 1'b1;
                state      <= DROP;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
        end

        DROP: begin
          if (trunc_pend) begin
            out_valid  <= 1'b1;
            out_data   <= hold;
            out_sof    <= first_pend;
            out_eof    <= 1'b1;
            out_err    <= 1'b1;
            err_cnt    <= sat_inc(err_cnt);
            trunc_pend <= 1'b0;
            hold_full  <= 1'b0;
            first_pend <= 1'b0;
          end
          if (!in_dv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
